serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; operands are sampled on the edge where it is accepted.
REQ-005 a  input  WIDTH  minuend.
REQ-006 b  input  WIDTH  subtrahend.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  unsigned borrow, set when a < b as unsigned values.
REQ-011 overflow  output  1  two's-complement overflow of a - b.
REQ-012 zero  output  1  set when diff is 0.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL latch a and b, clear the internal borrow flop and the bit counter, and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL process bit i, LSB first, one bit per clock:
- d = a_i ^ b_i ^ br
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
REQ-016 The d bit SHALL be shifted into the result register from the MSB side, so diff is bit-aligned after WIDTH shifts.
REQ-017 After the WIDTH-th SHIFT cycle, the FSM SHALL enter DONE.
REQ-018 DONE SHALL last one cycle and return to IDLE unless start=1 is accepted in DONE.
REQ-019 Latency SHALL be fixed: with start accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH+1.
REQ-020 busy SHALL be high from the edge after acceptance through the DONE cycle inclusive.
REQ-021 start SHALL be ignored while in SHIFT: no re-latch, no restart, no effect on the result.
REQ-022 overflow SHALL equal (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operands.
REQ-023 zero SHALL equal (diff == 0).
REQ-024 borrow_out SHALL equal the final borrow flop value.
REQ-025 diff, borrow_out, overflow and zero SHALL update only on entry to DONE, and SHALL hold until the next operation completes.
- They SHALL NOT change during SHIFT; partial results stay internal.
REQ-026 Changes on a and b after acceptance SHALL have no effect on the operation in progress.
REQ-027 start accepted in DONE SHALL begin a back-to-back operation with the same latency as from IDLE, and SHALL not drop the done pulse of the finishing operation.

Reset
REQ-028 While rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state to IDLE
- busy, done, diff, borrow_out, overflow, zero, counter and borrow flop to 0
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release SHALL run a complete, correct operation.
REQ-030 On the first rising edge after rst_n deasserts, the block SHALL be able to accept start.

Verification
REQ-031 WIDTH=32, a=5, b=3 -> done exactly 33 cycles after start edge; diff=2, borrow_out=0, overflow=0, zero=0.
REQ-032 a=3, b=5 -> diff=0xFFFFFFFE, borrow_out=1, overflow=0, zero=0.
REQ-033 Overflow cases:
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, overflow=1, borrow_out=0.
- a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, overflow=1, borrow_out=1.
REQ-034 a=b=0x12345678 -> diff=0, zero=1; then start held high in the DONE cycle with a=9, b=4 -> second done 33 cycles later with diff=5.
REQ-035 start pulsed at cycle 10 of SHIFT with different operands -> ignored; the original result is unchanged and done timing is unchanged.
REQ-036 rst_n low at cycle 15 of SHIFT -> all outputs 0 with no clock edge needed; no done pulse; a following operation 7-7 gives diff=0, zero=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned/two's-complement subtractor. An accepted start latches
// the operands; one bit per clock, LSB first, is passed through a full
// subtractor whose borrow is carried in a flop. The difference bits enter the
// partial-result register from the MSB side, so after WIDTH shifts it is
// bit-aligned. One further cycle registers the visible results and enters DONE.
//
// Handshake: start is a request. It is accepted on a rising edge when the FSM
// is in IDLE or DONE, and a and b are sampled on that same edge. start is
// ignored while SHIFT is in progress. done is a one-cycle pulse, and it is
// high while the results are first valid. busy is high from the edge after
// acceptance through the DONE cycle. done is high exactly in the cycle after
// edge k+WIDTH+1, where k is the acceptance edge.
//
// Ports:
//   clk         clock, rising edge active
//   rst_n       asynchronous active-low reset
//   start       request pulse
//   a, b        minuend / subtrahend (WIDTH bits)
//   busy        operation in progress (SHIFT or DONE)
//   done        one-cycle result-valid pulse
//   diff        a - b modulo 2^WIDTH, held until the next completion
//   borrow_out  unsigned borrow (a < b)
//   overflow    two's-complement overflow of a - b
//   zero        diff == 0
//   dbg_state   current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    // The counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    // All WIDTH bits have been processed; this SHIFT cycle only commits results.
    assign w_last    = (r_cnt == CW'(WIDTH));
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                // A start here begins the next operation without an idle gap.
                w_next = start ? SHIFT : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: operand shift registers, borrow flop, partial result, results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            // Sign bits are kept apart because the operand registers shift out.
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            if (!w_last) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CW'(1);
            end else begin
                // Visible results change only here, on the way into DONE.
                r_diff     <= r_res;
                r_borrow   <= r_br;
                r_overflow <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
                r_zero     <= (r_res == '0);
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_overflow;
    assign zero       = r_zero;
    assign dbg_state  = r_state;

endmodule
